// File: rtl/sr_cmd_pkg.sv
// Shared types and defaults for the SR command generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sr_cmd_pkg;

    // Default number of consecutive stable synced cycles needed to accept a level change.
    localparam int DB_CYCLES_DEF = 4;

    // Command FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    // Which channel owns the command currently in flight.
    typedef enum logic {
        OWN_SET = 1'b0,
        OWN_CLR = 1'b1
    } owner_t;

endpackage

// File: rtl/sr_debounce.sv
// Per-channel conditioner: 2-FF synchroniser, debounce counter, stable level and rise flag.
// Latency: pin change -> level change after 2 sync cycles plus DB_CYCLES stable cycles.
// Backpressure: none; free-running, the rise flag is a one-cycle strobe.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   btn        : raw asynchronous button input
//   level      : debounced (stable) level
//   rise       : high for one cycle after level goes 0 -> 1
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            // Any cycle agreeing with the accepted level restarts the run; the
            // counter tops out at DB_CYCLES-1 so it can never wrap.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns raw set/clear buttons into exclusive one-cycle S/R pulses for an SR flop.
// Latency: clean pin rise at edge 0 -> output pulse at edge 3+DB_CYCLES.
// Backpressure: none; edges arriving while a command is in flight are dropped and flagged.
//
// Ports:
//   clk, rst_n       : clock and asynchronous active-low reset
//   set_btn, clr_btn : raw asynchronous push-button inputs
//   s_out, r_out     : one-cycle set / reset pulses, never high together
//   busy             : high from the pulse until the owning button is released
//   conflict         : one-cycle pulse when a rising edge is discarded
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int PRIO_CLR  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s_out,
    output logic r_out,
    output logic busy,
    output logic conflict
);

    logic   set_level;
    logic   set_rise;
    logic   clr_level;
    logic   clr_rise;
    logic   win_clr;
    logic   owner_level;
    state_t state;
    owner_t owner;

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (set_btn),
        .level (set_level),
        .rise  (set_rise)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (clr_btn),
        .level (clr_level),
        .rise  (clr_rise)
    );

    // Clear takes the command if it rises alone, or on a tie when clear has priority.
    assign win_clr     = clr_rise & (~set_rise | (PRIO_CLR != 0));
    assign owner_level = (owner == OWN_CLR) ? clr_level : set_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= OWN_SET;
            s_out    <= 1'b0;
            r_out    <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            s_out    <= 1'b0;
            r_out    <= 1'b0;
            conflict <= 1'b0;
            case (state)
                IDLE: begin
                    if (set_rise || clr_rise) begin
                        state    <= PULSE;
                        owner    <= win_clr ? OWN_CLR : OWN_SET;
                        s_out    <= ~win_clr;
                        r_out    <= win_clr;
                        busy     <= 1'b1;
                        conflict <= set_rise & clr_rise;
                    end
                end
                PULSE: begin
                    state    <= WAIT_REL;
                    conflict <= set_rise | clr_rise;
                end
                WAIT_REL: begin
                    // Lockout: new edges are reported but never queued.
                    conflict <= set_rise | clr_rise;
                    if (!owner_level) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed and random checks of sr_cmd_gen with DB_CYCLES=4, both arbitration priorities.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_sr_cmd_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic set_btn;
    logic clr_btn;
    logic s1, r1, busy1, conf1;   // PRIO_CLR = 1
    logic s0, r0, busy0, conf0;   // PRIO_CLR = 0

    int tests = 0;
    int fails = 0;
    int s_cnt1 = 0;
    int r_cnt1 = 0;

    always #5 clk = ~clk;

    sr_cmd_gen #(.DB_CYCLES(4), .PRIO_CLR(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_btn  (set_btn),
        .clr_btn  (clr_btn),
        .s_out    (s1),
        .r_out    (r1),
        .busy     (busy1),
        .conflict (conf1)
    );

    sr_cmd_gen #(.DB_CYCLES(4), .PRIO_CLR(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_btn  (set_btn),
        .clr_btn  (clr_btn),
        .s_out    (s0),
        .r_out    (r0),
        .busy     (busy0),
        .conflict (conf0)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (s1) s_cnt1 = s_cnt1 + 1;
        if (r1) r_cnt1 = r_cnt1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base_s;
        int base_r;
        logic prev_s1, prev_r1, prev_s0, prev_r0;

        // ---------------- Reset state ----------------
        rst_n   = 1'b0;
        set_btn = 1'b0;
        clr_btn = 1'b0;
        #2;
        check("rst_s_out",    32'(s1),    0);
        check("rst_r_out",    32'(r1),    0);
        check("rst_busy",     32'(busy1), 0);
        check("rst_conflict", 32'(conf1), 0);
        step(3);
        rst_n = 1'b1;
        step(5);

        // ---------------- 1: clean set press ----------------
        base_s = s_cnt1;
        set_btn = 1'b1;                 // edge 0
        step(6);
        check("t1_s_before", 32'(s1), 0);
        step(1);                        // edge 7
        check("t1_s_pulse", 32'(s1), 1);
        check("t1_r_quiet", 32'(r1), 0);
        check("t1_busy_on", 32'(busy1), 1);
        step(1);
        check("t1_s_single", 32'(s1), 0);
        check("t1_busy_hold", 32'(busy1), 1);
        step(5);
        set_btn = 1'b0;                 // release at edge F
        step(6);
        check("t1_busy_before_rel", 32'(busy1), 1);
        step(1);
        check("t1_busy_off", 32'(busy1), 0);
        check("t1_pulse_count", 32'(s_cnt1 - base_s), 1);
        step(5);

        // ---------------- 2: bounce then hold ----------------
        base_s = s_cnt1;
        for (int i = 0; i < 5; i++) begin
            set_btn = 1'b1;
            step(2);
            set_btn = 1'b0;
            step(2);
        end
        set_btn = 1'b1;                 // final rise at edge B
        step(6);
        check("t2_s_before", 32'(s1), 0);
        check("t2_no_bounce_pulse", 32'(s_cnt1 - base_s), 0);
        step(1);
        check("t2_s_pulse", 32'(s1), 1);
        step(3);
        check("t2_pulse_count", 32'(s_cnt1 - base_s), 1);
        set_btn = 1'b0;
        step(10);
        check("t2_idle", 32'(busy1), 0);

        // ---------------- 3: simultaneous rise ----------------
        set_btn = 1'b1;
        clr_btn = 1'b1;
        step(7);
        check("t3_p1_r_out",    32'(r1),    1);
        check("t3_p1_s_out",    32'(s1),    0);
        check("t3_p1_conflict", 32'(conf1), 1);
        check("t3_p0_s_out",    32'(s0),    1);
        check("t3_p0_r_out",    32'(r0),    0);
        check("t3_p0_conflict", 32'(conf0), 1);
        step(1);
        check("t3_p1_conflict_end", 32'(conf1), 0);
        check("t3_p0_conflict_end", 32'(conf0), 0);
        check("t3_p1_r_single",     32'(r1),    0);
        check("t3_p0_s_single",     32'(s0),    0);
        set_btn = 1'b0;
        clr_btn = 1'b0;
        step(10);
        check("t3_p1_idle", 32'(busy1), 0);
        check("t3_p0_idle", 32'(busy0), 0);

        // ---------------- 4: lockout during WAIT_REL ----------------
        base_r = r_cnt1;
        set_btn = 1'b1;                 // edge E
        step(7);
        check("t4_s_pulse", 32'(s1), 1);
        step(3);
        clr_btn = 1'b1;                 // edge E+10, FSM in WAIT_REL
        step(6);
        check("t4_conflict_before", 32'(conf1), 0);
        step(1);
        check("t4_conflict", 32'(conf1), 1);
        check("t4_no_r", 32'(r1), 0);
        check("t4_busy", 32'(busy1), 1);
        step(1);
        check("t4_conflict_end", 32'(conf1), 0);
        set_btn = 1'b0;
        clr_btn = 1'b0;
        step(7);
        check("t4_idle", 32'(busy1), 0);
        check("t4_no_r_count", 32'(r_cnt1 - base_r), 0);
        step(5);
        clr_btn = 1'b1;                 // edge G
        step(6);
        check("t4_r_before", 32'(r1), 0);
        step(1);
        check("t4_r_pulse", 32'(r1), 1);
        check("t4_s_quiet", 32'(s1), 0);
        step(1);
        check("t4_r_single", 32'(r1), 0);
        clr_btn = 1'b0;
        step(10);

        // ---------------- 5: reset during PULSE ----------------
        set_btn = 1'b1;
        step(7);
        check("t5_s_pulse", 32'(s1), 1);
        #2;
        rst_n = 1'b0;                   // mid-cycle, no clock edge
        #1;
        check("t5_s_trunc", 32'(s1), 0);
        check("t5_busy_trunc", 32'(busy1), 0);
        step(2);
        rst_n = 1'b1;                   // release at edge R, set still held
        step(6);
        check("t5_s_before", 32'(s1), 0);
        step(1);
        check("t5_s_repulse", 32'(s1), 1);
        step(1);
        set_btn = 1'b0;
        step(10);
        check("t5_idle", 32'(busy1), 0);

        // ---------------- 6: random with invariants ----------------
        base_s = s_cnt1;
        base_r = r_cnt1;
        prev_s1 = 1'b0; prev_r1 = 1'b0; prev_s0 = 1'b0; prev_r0 = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) set_btn = ~set_btn;
            if ($urandom_range(0, 7) == 0) clr_btn = ~clr_btn;
            step(1);
            check("rnd_p1_excl",      32'(s1 & r1), 0);
            check("rnd_p0_excl",      32'(s0 & r0), 0);
            check("rnd_p1_b2b",       32'((s1 & prev_s1) | (r1 & prev_r1)), 0);
            check("rnd_p0_b2b",       32'((s0 & prev_s0) | (r0 & prev_r0)), 0);
            check("rnd_p1_pulse_busy", 32'((s1 | r1) & ~busy1), 0);
            check("rnd_p0_pulse_busy", 32'((s0 | r0) & ~busy0), 0);
            prev_s1 = s1; prev_r1 = r1; prev_s0 = s0; prev_r0 = r0;
        end
        check("rnd_activity", 32'((s_cnt1 - base_s) > 0 && (r_cnt1 - base_r) > 0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
